hmac_212_stream_if: RTL and testbench

HMAC_212_STREAM_IF -- requirements
Module: hmac_212_stream_if

---
 rtl/scrypt_pkg.sv | 15 +
 rtl/hmac_212_stream_if.sv | 142 ++++++++++++++
 tb/tb_hmac_212_stream_if.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scrypt_pkg.sv
// Shared sizing constants and FSM state encoding for the scrypt HMAC stream front end.
package scrypt_pkg;

    localparam int unsigned WORDS_IN  = 53;
    localparam int unsigned WORDS_OUT = 8;
    localparam int unsigned WORD_W    = 32;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/hmac_212_stream_if.sv
// Stream adapter around the HMAC core: collects a framed message into a wide
// word, fires the core once, then streams the captured hash back out word by word.
module hmac_212_stream_if #(
    parameter int unsigned WORDS_IN  = 53,
    parameter int unsigned WORDS_OUT = 8
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [31:0]               in_word,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [WORDS_IN*32-1:0]    core_data,
    output logic                      core_enable,
    input  logic [WORDS_OUT*32-1:0]   core_hash,
    input  logic                      core_hash_done,
    output logic [31:0]               out_word,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      frame_err
);
    import scrypt_pkg::*;

    localparam int unsigned DATA_W = WORDS_IN * WORD_W;
    localparam int unsigned HASH_W = WORDS_OUT * WORD_W;
    localparam int unsigned CNT_W  = $clog2(WORDS_IN);
    localparam int unsigned OCNT_W = $clog2(WORDS_OUT);
    localparam int unsigned POS_W  = $clog2(DATA_W);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [OCNT_W-1:0]   r_out_cnt;
    logic [DATA_W-1:0]   r_core_data;
    logic [HASH_W-1:0]   r_hash;
    logic                r_in_ready;
    logic                r_core_enable;
    logic                r_out_valid;
    logic                r_frame_err;

    logic                w_xfer;
    logic                w_last_word;
    logic                w_out_hs;
    logic                w_bad;
    logic                w_fire;
    logic                w_capture;
    logic [POS_W-1:0]    w_wr_lsb;

    // in_ready is only ever high in LOAD, so it fully qualifies an input transfer
    assign w_xfer      = in_valid & r_in_ready;
    assign w_last_word = (r_cnt == CNT_W'(WORDS_IN - 1));
    assign w_out_hs    = r_out_valid & out_ready;
    // word k lands at the MSB end first: lsb = (WORDS_IN-1-k)*32
    assign w_wr_lsb    = POS_W'((WORDS_IN - 1 - 32'(r_cnt)) * WORD_W);

    // Next-state and event decode
    always_comb begin
        w_state_nxt = r_state;
        w_bad       = 1'b0;
        w_fire      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (w_xfer) begin
                    if (w_last_word && in_last) begin
                        w_fire      = 1'b1;
                        w_state_nxt = ST_FIRE;
                    end else if (w_last_word || in_last) begin
                        w_bad = 1'b1;
                    end
                end
            end
            ST_FIRE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (core_hash_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_out_hs && (r_out_cnt == OCNT_W'(WORDS_OUT - 1))) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    // State register and registered control outputs derived from the next state
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state       <= ST_LOAD;
            r_in_ready    <= 1'b0;
            r_core_enable <= 1'b0;
            r_out_valid   <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_in_ready    <= (w_state_nxt == ST_LOAD);
            r_core_enable <= (w_state_nxt == ST_FIRE);
            r_out_valid   <= (w_state_nxt == ST_DRAIN);
            r_frame_err   <= w_bad;
        end
    end

    // Message assembly; a framing error or a fire restarts the word count
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_cnt       <= '0;
            r_core_data <= '0;
        end else if (w_xfer) begin
            r_core_data[w_wr_lsb +: WORD_W] <= in_word;
            if (w_fire || w_bad) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Hash capture and drain: the register shifts left so out_word is always its top word
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_hash    <= '0;
            r_out_cnt <= '0;
        end else if (w_capture) begin
            r_hash    <= core_hash;
            r_out_cnt <= '0;
        end else if (w_out_hs) begin
            r_hash    <= {r_hash[HASH_W-WORD_W-1:0], {WORD_W{1'b0}}};
            r_out_cnt <= r_out_cnt + OCNT_W'(1);
        end
    end

    assign in_ready    = r_in_ready;
    assign core_data   = r_core_data;
    assign core_enable = r_core_enable;
    assign out_word    = r_hash[HASH_W-1 -: WORD_W];
    assign out_valid   = r_out_valid;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_hmac_212_stream_if.sv
// Self-checking bench for hmac_212_stream_if: transaction-level reference model
// plus directed scenarios with hand-computed expectations.
module tb_hmac_212_stream_if;

    localparam int DATA_W = 53 * 32;

    logic              clk;
    logic              n_rst;
    logic [31:0]       in_word;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] core_data;
    logic              core_enable;
    logic [255:0]      core_hash;
    logic              core_hash_done;
    logic [31:0]       out_word;
    logic              out_valid;
    logic              out_ready;
    logic              frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    hmac_212_stream_if #(.WORDS_IN(53), .WORDS_OUT(8)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .in_word        (in_word),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .core_data      (core_data),
        .core_enable    (core_enable),
        .core_hash      (core_hash),
        .core_hash_done (core_hash_done),
        .out_word       (out_word),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .frame_err      (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            for (int k = 0; k < 53; k++) begin
                if (act[DATA_W-1-32*k -: 32] !== exp[DATA_W-1-32*k -: 32]) begin
                    $display("FAIL %s: word %0d got %h expected %h (t=%0t)", name, k,
                             act[DATA_W-1-32*k -: 32], exp[DATA_W-1-32*k -: 32], $time);
                    break;
                end
            end
        end
    endtask

    // ---------------- reference model (message/queue level) ----------------
    localparam int M_LOAD = 0, M_FIRE = 1, M_WAIT = 2, M_DRAIN = 3;
    int                m_mode    = M_LOAD;
    logic [31:0]       m_msg[$];
    logic [31:0]       m_out[$];
    bit                m_rst_blk = 1'b1;
    bit                m_ferr    = 1'b0;
    bit                m_started = 1'b0;
    logic [DATA_W-1:0] m_data    = '0;

    initial begin
        forever begin
            @(posedge clk);
            m_started = 1'b1;
            m_ferr    = 1'b0;
            if (n_rst) begin
                m_mode    = M_LOAD;
                m_rst_blk = 1'b1;
                m_data    = '0;
                m_msg.delete();
                m_out.delete();
            end else begin
                bit rdy;
                rdy       = (m_mode == M_LOAD) && !m_rst_blk;
                m_rst_blk = 1'b0;
                case (m_mode)
                    M_LOAD: if (in_valid && rdy) begin
                        m_msg.push_back(in_word);
                        if (m_msg.size() == 53) begin
                            if (in_last) begin
                                for (int k = 0; k < 53; k++) m_data[DATA_W-1-32*k -: 32] = m_msg[k];
                                m_mode = M_FIRE;
                            end else begin
                                m_ferr = 1'b1;
                            end
                            m_msg.delete();
                        end else if (in_last) begin
                            m_ferr = 1'b1;
                            m_msg.delete();
                        end
                    end
                    M_FIRE: m_mode = M_WAIT;
                    M_WAIT: if (core_hash_done) begin
                        for (int j = 0; j < 8; j++) m_out.push_back(core_hash[255-32*j -: 32]);
                        m_mode = M_DRAIN;
                    end
                    default: if (out_ready) begin
                        void'(m_out.pop_front());
                        if (m_out.size() == 0) m_mode = M_LOAD;
                    end
                endcase
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                chk("m_in_ready", in_ready, (m_mode == M_LOAD) && !m_rst_blk);
                chk("m_core_enable", core_enable, m_mode == M_FIRE);
                chk("m_out_valid", out_valid, m_mode == M_DRAIN);
                chk("m_frame_err", frame_err, m_ferr);
                if (m_mode == M_DRAIN && m_out.size() > 0) chk("m_out_word", out_word, m_out[0]);
                if (m_mode == M_FIRE || m_mode == M_WAIT) chk_data("m_core_data", core_data, m_data);
                if (m_rst_blk) begin
                    chk_data("m_rst_core_data", core_data, '0);
                    chk("m_rst_out_word", out_word, 0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [255:0] mk_hash(input logic [31:0] base);
        logic [255:0] h;
        h = '0;
        for (int j = 0; j < 8; j++) h[255-32*j -: 32] = base + 32'(j);
        return h;
    endfunction

    // Called at posedge+1 in LOAD with in_ready high; returns at posedge+1 after the last transfer
    task automatic send_msg(input logic [31:0] base, input int n, input int last_at, input bit stall);
        for (int k = 0; k < n; k++) begin
            if (stall && (k % 7 == 3)) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_word  = base + 32'(k);
            in_last  = (k == last_at);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic core_done(input logic [255:0] h, input int dly);
        repeat (dly) @(posedge clk);
        #1;
        core_hash      = h;
        core_hash_done = 1'b1;
        @(posedge clk); #1;
        core_hash_done = 1'b0;
        core_hash      = '0;
    endtask

    // Collects the 8 drained words; stall=1 drives out_ready 1,0,0,1 repeating
    task automatic drain(input bit stall, input logic [31:0] base);
        logic [31:0] got [8];
        int ngot, c, first, lastc;
        ngot = 0; c = 0; first = -1; lastc = -1;
        out_ready = 1'b1;
        while (ngot < 8 && c < 200) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready) begin
                got[ngot] = out_word;
                if (first < 0) first = c;
                lastc = c;
                ngot++;
            end
            @(posedge clk); #1;
            c++;
            out_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
        end
        out_ready = 1'b1;
        chk("drain_count", 256'(ngot), 8);
        chk("drain_first_latency", 256'(first), 0);
        for (int j = 0; j < ngot; j++) chk("drain_word", got[j], base + 32'(j));
        if (!stall) chk("drain_consecutive", 256'(lastc - first), 7);
        @(negedge clk);
        chk("ready_after_drain", in_ready, 1);
        @(posedge clk); #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        n_rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_word = '0;
        core_hash = '0; core_hash_done = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_core_enable", core_enable, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_out_word", out_word, 0);
        chk_data("rst_core_data", core_data, '0);
        n_rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // Words 0x00..0x34 with no stalls, core answers with word j = j
        send_msg(32'h0000_0000, 53, 52, 1'b0);
        @(negedge clk);
        chk("fire_pulse", core_enable, 1);
        chk("fire_in_ready", in_ready, 0);
        chk("fire_data_msb", core_data[1695:1664], 32'h0000_0000);
        chk("fire_data_lsb", core_data[31:0], 32'h0000_0034);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fire_one_cycle", core_enable, 0);
        core_done(mk_hash(32'h0), 9);
        drain(1'b0, 32'h0);

        // Stalled input, out_ready toggling 1,0,0,1 during drain
        send_msg(32'h0000_1000, 53, 52, 1'b1);
        @(negedge clk);
        chk("fire2_pulse", core_enable, 1);
        chk("fire2_data_lsb", core_data[31:0], 32'h0000_1034);
        core_done(mk_hash(32'hA5A5_0000), 3);
        drain(1'b1, 32'hA5A5_0000);

        // Early in_last on word 10, then a normal message
        send_msg(32'h0000_2000, 11, 10, 1'b0);
        @(negedge clk);
        chk("ferr_early_pulse", frame_err, 1);
        chk("ferr_early_no_fire", core_enable, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ferr_early_one_cycle", frame_err, 0);
        chk("ferr_early_ready", in_ready, 1);
        @(posedge clk); #1;
        send_msg(32'h0000_3000, 53, 52, 1'b0);
        @(negedge clk);
        chk("fire3_pulse", core_enable, 1);
        chk("fire3_data_msb", core_data[1695:1664], 32'h0000_3000);
        chk("fire3_data_lsb", core_data[31:0], 32'h0000_3034);
        core_done(mk_hash(32'h0), 10);
        drain(1'b0, 32'h0);

        // Missing in_last on word 52
        send_msg(32'h0000_4000, 53, -1, 1'b0);
        @(negedge clk);
        chk("ferr_late_pulse", frame_err, 1);
        chk("ferr_late_no_fire", core_enable, 0);
        @(posedge clk); #1;

        // Spurious core_hash_done while loading
        core_hash = {8{32'hFFFF_FFFF}};
        core_hash_done = 1'b1;
        @(posedge clk); #1;
        core_hash_done = 1'b0;
        core_hash = '0;
        repeat (3) begin
            @(negedge clk);
            chk("spurious_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end

        // Reset in the middle of DRAIN
        send_msg(32'h0000_5000, 53, 52, 1'b0);
        @(negedge clk);
        core_done(mk_hash(32'h0000_0100), 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_word", out_word, 0);
        chk("mid_rst_core_enable", core_enable, 0);
        chk("mid_rst_frame_err", frame_err, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk_data("mid_rst_core_data", core_data, '0);
        n_rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_load_ready", in_ready, 1);
        chk("mid_rst_still_idle", out_valid, 0);
        @(posedge clk); #1;
        core_hash = mk_hash(32'h0000_0200);
        core_hash_done = 1'b1;
        @(posedge clk); #1;
        core_hash_done = 1'b0;
        core_hash = '0;
        @(negedge clk);
        chk("late_done_ignored", out_valid, 0);
        @(posedge clk); #1;

        // Reset while waiting on the core; the late result is dropped
        send_msg(32'h0000_6000, 53, 52, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        n_rst = 1'b0;
        @(posedge clk); #1;
        core_hash = mk_hash(32'h0000_0300);
        core_hash_done = 1'b1;
        @(posedge clk); #1;
        core_hash_done = 1'b0;
        core_hash = '0;
        @(negedge clk);
        chk("wait_rst_done_ignored", out_valid, 0);
        chk("wait_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
